dll_cmd_arbiter: RTL and testbench
==================================

Name: dll_cmd_arbiter

Overview:
Shares the single command port of the doubly linked list controller between REQ_N independent requesters.
- Round-robin arbitration, one command per cycle maximum.
- Keeps shadow per-id and total occupancy counts, so illegal push/pop is rejected before it reaches the controller.
- Enforces the same-id back-to-back hazard rule.
- Sequences the list clear operation.
- Sits directly in front of doubly_linked_list_cntrl and returns the pointer produced by each command to the requester that issued it.

Parameters:
- REQ_N, 4, number of requesters (≥2).
- ID_N, dll_pkg::ID_N, number of queues.
- PTR_N, dll_pkg::PTR_N, total list entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_vld  in  REQ_N  per-requester command valid
- req_op  in  REQ_N×$bits(op_t)  per-requester op; op[OP_PUSH_B]=1 is push, else pop
- req_id  in  REQ_N×$bits(id_t)  per-requester queue id
- req_rdy  out  REQ_N  one-hot; request consumed this cycle
- cmd_pass  out  1  command to controller
- cmd_op  out  $bits(op_t)  command op
- cmd_id  out  $bits(id_t)  command id
- cmd_push_ptr_r  in  $bits(ptr_t)  controller push pointer
- cmd_pop_ptr_w  in  $bits(ptr_t)  controller pop pointer
- clear  out  1  clear strobe to controller
- busy_r  in  1  controller busy
- clr_req  in  1  software clear request, level
- clr_done  out  1  one-cycle pulse, clear complete
- rsp_vld  out  1  response valid
- rsp_req  out  $clog2(REQ_N)  index of the responding requester
- rsp_ptr  out  $bits(ptr_t)  pointer pushed or popped
- rsp_err  out  1  command rejected

Behaviour:
- Reset: all of the following are 0 — req_rdy, cmd_pass, clear, clr_done, rsp_* and the shadow counts. RR pointer = 0. State = IDLE.
- Eligibility of requester i:
  - req_vld[i]=1, state is IDLE, and clr_req=0.
  - Not blocked: req_id[i] equals the id issued with cmd_pass in the previous cycle. That requester waits one cycle; other ids may go back-to-back.
- Grant:
  - Round-robin over eligible requesters, starting at rr_ptr.
  - On grant, rr_ptr = winner+1 mod REQ_N.
  - Exactly one req_rdy per cycle, combinational in the same cycle as req_vld.
- Legality, using shadow counts in the grant cycle:
  - Push is legal if tot_cnt < PTR_N.
  - Pop is legal if cnt[id] != 0.
- Legal grant:
  - cmd_pass=1 with cmd_op/cmd_id from the winner.
  - Push: cnt[id]++ and tot_cnt++. Pop: both decrement.
  - Counts update at the next edge.
- Illegal grant: req_rdy=1, cmd_pass=0, no count change, rsp_err=1.
- Response:
  - Registered, latency 1 after grant: rsp_vld=1 and rsp_req=winner.
  - rsp_ptr = cmd_push_ptr_r (push) or cmd_pop_ptr_w (pop), sampled in the grant cycle.
  - rsp_ptr = 0 when rsp_err=1.
- Count widths: cnt[] and tot_cnt are $clog2(PTR_N+1) bits. They never wrap, by construction.
- FSM:
  - IDLE: on clr_req, go to DRAIN. No grant is made in the cycle clr_req is seen.
  - DRAIN: wait for busy_r=0, then go to CLR.
  - CLR: clear=1 for one cycle; all counts zeroed and rr_ptr=0; go to DONE.
  - DONE: clr_done=1 for one cycle; return to IDLE. A still-high clr_req causes no re-trigger until it has been seen low.
- Simultaneous events: clr_req takes precedence over any pending grant. A response registered in the previous cycle still issues.
- Reset mid-clear: return to IDLE without pulsing clear.

Optional Feature:
- Macro DLL_ARB_STATS_EN.
- Defined: adds 32-bit saturating counters stat_push_r, stat_pop_r, stat_rej_r as outputs.
  - Each increments on the corresponding grant.
  - All reset by rst or the CLR state.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- dll_pkg already holds op_t, id_t, ptr_t, ID_N, PTR_N and OP_PUSH_B.
- Add to dll_pkg: arb_state_t (IDLE/DRAIN/CLR/DONE) and cnt_t (width $clog2(PTR_N+1)).
- One sub-module: rr_arb (REQ_N-wide round-robin picker: req vector plus pointer in, one-hot grant out), instanced once.

Test Plan:
1. After reset, r0 pushes id 2 → cmd_pass=1, cmd_id=2; next cycle rsp_vld=1, rsp_req=0, rsp_ptr=cmd_push_ptr_r value (1).
2. r0..r3 all push distinct ids continuously → grants rotate 0,1,2,3,0 on successive cycles; one cmd_pass per cycle.
3. r1 pops id 3 while id 3 is empty → req_rdy[1]=1, cmd_pass=0; next cycle rsp_err=1, rsp_ptr=0.
4. PTR_N=8; fill with 8 pushes, then a 9th push → rejected with rsp_err=1; a subsequent pop is legal; the following push succeeds.
5. r0 and r1 both target id 1 on consecutive cycles → the second command is delayed one cycle; a different id in between is granted.
6. clr_req held while busy_r=1 for 3 cycles → no grants; clear pulses after busy_r falls; clr_done on the next cycle; a pop afterwards is rejected.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types for the doubly linked list controller and its command arbiter.
package dll_pkg;

  localparam int unsigned ID_N      = 4;
  localparam int unsigned PTR_N     = 8;
  localparam int unsigned OP_PUSH_B = 0;

  typedef logic [1:0]                   op_t;
  typedef logic [$clog2(ID_N)-1:0]      id_t;
  typedef logic [$clog2(PTR_N)-1:0]     ptr_t;
  typedef logic [$clog2(PTR_N+1)-1:0]   cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StClr,
    StDone
  } arb_state_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: the first set request at or after ptr_i (wrapping) wins.
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  localparam int unsigned PW = $clog2(N);

  logic          found;
  int unsigned   idx;
  logic [PW-1:0] sel;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      sel = PW'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dll_cmd_arbiter.sv
// Shares the controller command port between REQ_N requesters and sequences list clear.
// Define DLL_ARB_STATS_EN to add saturating push/pop/reject grant counters.
module dll_cmd_arbiter
  import dll_pkg::*;
#(
  parameter int unsigned REQ_N = 4,
  parameter int unsigned ID_N  = dll_pkg::ID_N,
  parameter int unsigned PTR_N = dll_pkg::PTR_N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_N-1:0]              req_vld,
  input  logic [REQ_N*$bits(op_t)-1:0]  req_op,
  input  logic [REQ_N*$bits(id_t)-1:0]  req_id,
  output logic [REQ_N-1:0]              req_rdy,
  output logic                          cmd_pass,
  output logic [$bits(op_t)-1:0]        cmd_op,
  output logic [$bits(id_t)-1:0]        cmd_id,
  input  logic [$bits(ptr_t)-1:0]       cmd_push_ptr_r,
  input  logic [$bits(ptr_t)-1:0]       cmd_pop_ptr_w,
  output logic                          clear,
  input  logic                          busy_r,
  input  logic                          clr_req,
  output logic                          clr_done,
  output logic                          rsp_vld,
  output logic [$clog2(REQ_N)-1:0]      rsp_req,
  output logic [$bits(ptr_t)-1:0]       rsp_ptr,
  output logic                          rsp_err
`ifdef DLL_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_push_r,
  output logic [31:0]                   stat_pop_r,
  output logic [31:0]                   stat_rej_r
`endif
);

  localparam int unsigned RW = $clog2(REQ_N);
  localparam int unsigned OW = $bits(op_t);
  localparam int unsigned IW = $bits(id_t);

  arb_state_t     state_q, state_d;
  logic [RW-1:0]  rr_ptr_q, rr_next;
  cnt_t           cnt_q [ID_N];
  cnt_t           tot_q;
  logic           last_pass_q;
  id_t            last_id_q;
  logic           clr_arm_q, clr_arm_d;

  logic [REQ_N-1:0] elig, gnt;
  logic             gnt_any, win_push, legal;
  logic [RW-1:0]    win;
  op_t              win_op;
  id_t              win_id;

  // An id issued last cycle must wait one cycle; other ids may follow immediately.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(REQ_N); i++) begin
      elig[i] = req_vld[i] && (state_q == StIdle) && !clr_req &&
                !(last_pass_q && (req_id[i*IW +: IW] == last_id_q));
    end
  end

  rr_arb #(
    .N(REQ_N)
  ) u_rr_arb (
    .req_i(elig),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt)
  );

  always_comb begin
    win    = '0;
    win_op = '0;
    win_id = '0;
    for (int i = 0; i < int'(REQ_N); i++) begin
      if (gnt[i]) begin
        win    = RW'(i);
        win_op = req_op[i*OW +: OW];
        win_id = req_id[i*IW +: IW];
      end
    end
  end

  assign gnt_any  = |gnt;
  assign win_push = win_op[OP_PUSH_B];
  assign legal    = win_push ? (tot_q < cnt_t'(PTR_N)) : (cnt_q[win_id] != '0);
  assign rr_next  = (win == RW'(REQ_N - 1)) ? '0 : win + RW'(1);

  assign req_rdy  = gnt;
  assign cmd_pass = gnt_any && legal;
  assign cmd_op   = win_op;
  assign cmd_id   = win_id;
  assign clear    = (state_q == StClr);
  assign clr_done = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    clr_arm_d = clr_arm_q;
    // A clear request held across completion must drop before it can re-trigger.
    if (!clr_req) clr_arm_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (clr_req && clr_arm_q) begin
          state_d   = StDrain;
          clr_arm_d = 1'b0;
        end
      end
      StDrain: if (!busy_r) state_d = StClr;
      StClr:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      clr_arm_q   <= 1'b1;
      rr_ptr_q    <= '0;
      tot_q       <= '0;
      for (int i = 0; i < int'(ID_N); i++) cnt_q[i] <= '0;
      last_pass_q <= 1'b0;
      last_id_q   <= '0;
      rsp_vld     <= 1'b0;
      rsp_req     <= '0;
      rsp_ptr     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_arm_q   <= clr_arm_d;
      last_pass_q <= cmd_pass;
      last_id_q   <= win_id;
      rsp_vld     <= gnt_any;
      rsp_req     <= win;
      rsp_err     <= gnt_any && !legal;
      rsp_ptr     <= !cmd_pass ? '0 : (win_push ? cmd_push_ptr_r : cmd_pop_ptr_w);
      if (state_q == StClr) begin
        rr_ptr_q <= '0;
        tot_q    <= '0;
        for (int i = 0; i < int'(ID_N); i++) cnt_q[i] <= '0;
      end else if (gnt_any) begin
        rr_ptr_q <= rr_next;
        if (legal) begin
          if (win_push) begin
            cnt_q[win_id] <= cnt_q[win_id] + cnt_t'(1);
            tot_q         <= tot_q + cnt_t'(1);
          end else begin
            cnt_q[win_id] <= cnt_q[win_id] - cnt_t'(1);
            tot_q         <= tot_q - cnt_t'(1);
          end
        end
      end
    end
  end

`ifdef DLL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state_q == StClr)) begin
      stat_push_r <= '0;
      stat_pop_r  <= '0;
      stat_rej_r  <= '0;
    end else begin
      if (cmd_pass && win_push && (stat_push_r != '1)) stat_push_r <= stat_push_r + 32'd1;
      if (cmd_pass && !win_push && (stat_pop_r != '1)) stat_pop_r <= stat_pop_r + 32'd1;
      if (gnt_any && !legal && (stat_rej_r != '1)) stat_rej_r <= stat_rej_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dll_cmd_arbiter.sv
// Directed self-checking bench for dll_cmd_arbiter (4 requesters, 4 ids, 8 entries).
module tb_dll_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vld;
  logic [7:0] req_op;
  logic [7:0] req_id;
  logic [3:0] req_rdy;
  logic       cmd_pass;
  logic [1:0] cmd_op;
  logic [1:0] cmd_id;
  logic [2:0] cmd_push_ptr_r;
  logic [2:0] cmd_pop_ptr_w;
  logic       clear;
  logic       busy_r;
  logic       clr_req;
  logic       clr_done;
  logic       rsp_vld;
  logic [1:0] rsp_req;
  logic [2:0] rsp_ptr;
  logic       rsp_err;
`ifdef DLL_ARB_STATS_EN
  logic [31:0] stat_push_r, stat_pop_r, stat_rej_r;
`endif

  int checks   = 0;
  int failures = 0;

  dll_cmd_arbiter #(
    .REQ_N(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_op(req_op),
    .req_id(req_id),
    .req_rdy(req_rdy),
    .cmd_pass(cmd_pass),
    .cmd_op(cmd_op),
    .cmd_id(cmd_id),
    .cmd_push_ptr_r(cmd_push_ptr_r),
    .cmd_pop_ptr_w(cmd_pop_ptr_w),
    .clear(clear),
    .busy_r(busy_r),
    .clr_req(clr_req),
    .clr_done(clr_done),
    .rsp_vld(rsp_vld),
    .rsp_req(rsp_req),
    .rsp_ptr(rsp_ptr),
    .rsp_err(rsp_err)
`ifdef DLL_ARB_STATS_EN
    ,
    .stat_push_r(stat_push_r),
    .stat_pop_r(stat_pop_r),
    .stat_rej_r(stat_rej_r)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic push, input logic [1:0] id);
    req_vld[i]       = v;
    req_op[i*2 +: 2] = push ? 2'b01 : 2'b00;
    req_id[i*2 +: 2] = id;
  endtask

  task automatic apply_reset;
    rst            = 1'b1;
    req_vld        = '0;
    req_op         = '0;
    req_id         = '0;
    busy_r         = 1'b0;
    clr_req        = 1'b0;
    cmd_push_ptr_r = '0;
    cmd_pop_ptr_w  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_vld = '0; req_op = '0; req_id = '0;
    busy_r = 1'b0; clr_req = 1'b0; cmd_push_ptr_r = '0; cmd_pop_ptr_w = '0;
    tick();
    tick();
    checks++;
    if ({req_rdy, cmd_pass, clear, clr_done, rsp_vld, rsp_req, rsp_err, rsp_ptr} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b pass=%b clr=%b done=%b vld=%b req=%0d err=%b ptr=%0d",
               req_rdy, cmd_pass, clear, clr_done, rsp_vld, rsp_req, rsp_err, rsp_ptr);
    end
    rst = 1'b0;
  endtask

  task automatic test_push_single;
    apply_reset();
    cmd_push_ptr_r = 3'd1;
    cmd_pop_ptr_w  = 3'd5;
    set_req(0, 1'b1, 1'b1, 2'd2);
    #1;
    checks++;
    if ({req_rdy, cmd_pass, cmd_op, cmd_id} !== {4'b0001, 1'b1, 2'b01, 2'd2}) begin
      failures++;
      $display("FAIL push_grant: got rdy=%b pass=%b op=%b id=%0d want 0001 1 01 2",
               req_rdy, cmd_pass, cmd_op, cmd_id);
    end
    tick();
    set_req(0, 1'b0, 1'b1, 2'd2);
    checks++;
    if ({rsp_vld, rsp_req, rsp_err, rsp_ptr} !== {1'b1, 2'd0, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL push_rsp: got vld=%b req=%0d err=%b ptr=%0d want 1 0 0 1",
               rsp_vld, rsp_req, rsp_err, rsp_ptr);
    end
    tick();
    checks++;
    if (rsp_vld !== 1'b0) begin
      failures++;
      $display("FAIL push_rsp_once: got vld=%b want 0", rsp_vld);
    end
  endtask

  task automatic test_rotate;
    logic [1:0] w;
    apply_reset();
    cmd_push_ptr_r = 3'd4;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 2'(i));
    for (int k = 0; k < 5; k++) begin
      w = 2'(k % 4);
      #1;
      checks++;
      if ({req_rdy, cmd_pass, cmd_id} !== {4'b0001 << w, 1'b1, w}) begin
        failures++;
        $display("FAIL rotate_grant[%0d]: got rdy=%b pass=%b id=%0d want rdy=%b 1 %0d",
                 k, req_rdy, cmd_pass, cmd_id, 4'b0001 << w, w);
      end
      tick();
      checks++;
      if ({rsp_vld, rsp_req, rsp_err} !== {1'b1, w, 1'b0}) begin
        failures++;
        $display("FAIL rotate_rsp[%0d]: got vld=%b req=%0d err=%b want 1 %0d 0",
                 k, rsp_vld, rsp_req, rsp_err, w);
      end
    end
    req_vld = '0;
  endtask

  task automatic test_pop_empty;
    apply_reset();
    cmd_pop_ptr_w = 3'd5;
    set_req(1, 1'b1, 1'b0, 2'd3);
    #1;
    checks++;
    if ({req_rdy, cmd_pass} !== {4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL pop_empty_grant: got rdy=%b pass=%b want 0010 0", req_rdy, cmd_pass);
    end
    tick();
    req_vld = '0;
    checks++;
    if ({rsp_vld, rsp_req, rsp_err, rsp_ptr} !== {1'b1, 2'd1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL pop_empty_rsp: got vld=%b req=%0d err=%b ptr=%0d want 1 1 1 0",
               rsp_vld, rsp_req, rsp_err, rsp_ptr);
    end
  endtask

  task automatic test_full;
    apply_reset();
    cmd_push_ptr_r = 3'd2;
    cmd_pop_ptr_w  = 3'd6;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 1'b1, 2'(k % 2));
      #1;
      checks++;
      if ({req_rdy, cmd_pass} !== {4'b0001, 1'b1}) begin
        failures++;
        $display("FAIL fill_push[%0d]: got rdy=%b pass=%b want 0001 1", k, req_rdy, cmd_pass);
      end
      tick();
    end
    set_req(0, 1'b1, 1'b1, 2'd2);
    #1;
    checks++;
    if ({req_rdy, cmd_pass} !== {4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL full_push_grant: got rdy=%b pass=%b want 0001 0", req_rdy, cmd_pass);
    end
    tick();
    checks++;
    if ({rsp_vld, rsp_err, rsp_ptr} !== {1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL full_push_rsp: got vld=%b err=%b ptr=%0d want 1 1 0", rsp_vld, rsp_err, rsp_ptr);
    end
    set_req(0, 1'b1, 1'b0, 2'd0);
    #1;
    checks++;
    if ({cmd_pass, cmd_op, cmd_id} !== {1'b1, 2'b00, 2'd0}) begin
      failures++;
      $display("FAIL full_pop_grant: got pass=%b op=%b id=%0d want 1 00 0", cmd_pass, cmd_op, cmd_id);
    end
    tick();
    checks++;
    if ({rsp_err, rsp_ptr} !== {1'b0, 3'd6}) begin
      failures++;
      $display("FAIL full_pop_rsp: got err=%b ptr=%0d want 0 6", rsp_err, rsp_ptr);
    end
    set_req(0, 1'b1, 1'b1, 2'd1);
    #1;
    checks++;
    if (cmd_pass !== 1'b1) begin
      failures++;
      $display("FAIL refill_push_grant: got pass=%b want 1", cmd_pass);
    end
    tick();
    req_vld = '0;
    checks++;
    if ({rsp_err, rsp_ptr} !== {1'b0, 3'd2}) begin
      failures++;
      $display("FAIL refill_push_rsp: got err=%b ptr=%0d want 0 2", rsp_err, rsp_ptr);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_req(0, 1'b1, 1'b1, 2'd1);
    #1;
    checks++;
    if ({req_rdy, cmd_pass} !== {4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL b2b_first: got rdy=%b pass=%b want 0001 1", req_rdy, cmd_pass);
    end
    tick();
    set_req(0, 1'b0, 1'b1, 2'd1);
    set_req(1, 1'b1, 1'b1, 2'd1);
    set_req(2, 1'b1, 1'b1, 2'd0);
    #1;
    checks++;
    if ({req_rdy, cmd_pass, cmd_id} !== {4'b0100, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL b2b_other_id: got rdy=%b pass=%b id=%0d want 0100 1 0", req_rdy, cmd_pass, cmd_id);
    end
    tick();
    set_req(2, 1'b0, 1'b1, 2'd0);
    #1;
    checks++;
    if ({req_rdy, cmd_pass, cmd_id} !== {4'b0010, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL b2b_delayed: got rdy=%b pass=%b id=%0d want 0010 1 1", req_rdy, cmd_pass, cmd_id);
    end
    tick();
    #1;
    checks++;
    if ({req_rdy, cmd_pass} !== {4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL b2b_blocked: got rdy=%b pass=%b want 0000 0", req_rdy, cmd_pass);
    end
    tick();
    #1;
    checks++;
    if ({req_rdy, cmd_pass} !== {4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL b2b_release: got rdy=%b pass=%b want 0010 1", req_rdy, cmd_pass);
    end
    tick();
    req_vld = '0;
  endtask

  task automatic test_clear;
    apply_reset();
    set_req(0, 1'b1, 1'b1, 2'd3);
    #1;
    checks++;
    if (cmd_pass !== 1'b1) begin
      failures++;
      $display("FAIL clr_prefill: got pass=%b want 1", cmd_pass);
    end
    tick();
    req_vld = '0;
    clr_req = 1'b1;
    busy_r  = 1'b1;
    set_req(1, 1'b1, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({req_rdy, cmd_pass, clear, clr_done} !== 7'd0) begin
        failures++;
        $display("FAIL clr_busy[%0d]: got rdy=%b pass=%b clr=%b done=%b want all 0",
                 k, req_rdy, cmd_pass, clear, clr_done);
      end
      tick();
    end
    busy_r = 1'b0;
    #1;
    checks++;
    if ({clear, req_rdy} !== 5'd0) begin
      failures++;
      $display("FAIL clr_drain_last: got clr=%b rdy=%b want 0 0000", clear, req_rdy);
    end
    tick();
    checks++;
    if ({clear, clr_done, req_rdy} !== {1'b1, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL clr_pulse: got clr=%b done=%b rdy=%b want 1 0 0000", clear, clr_done, req_rdy);
    end
    tick();
    checks++;
    if ({clear, clr_done} !== 2'b01) begin
      failures++;
      $display("FAIL clr_done_pulse: got clr=%b done=%b want 0 1", clear, clr_done);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({clear, clr_done, req_rdy} !== 6'd0) begin
        failures++;
        $display("FAIL clr_no_retrigger[%0d]: got clr=%b done=%b rdy=%b want all 0",
                 k, clear, clr_done, req_rdy);
      end
    end
    tick();
    clr_req = 1'b0;
    req_vld = '0;
    set_req(0, 1'b1, 1'b0, 2'd3);
    #1;
    checks++;
    if ({req_rdy, cmd_pass, clear} !== {4'b0001, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_pop_grant: got rdy=%b pass=%b clr=%b want 0001 0 0", req_rdy, cmd_pass, clear);
    end
    tick();
    req_vld = '0;
    checks++;
    if ({rsp_vld, rsp_err} !== 2'b11) begin
      failures++;
      $display("FAIL clr_pop_rsp: got vld=%b err=%b want 1 1", rsp_vld, rsp_err);
    end
  endtask

  task automatic test_reset_mid_clear;
    apply_reset();
    clr_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({clear, clr_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_clr: got clr=%b done=%b want 0 0", clear, clr_done);
    end
    rst     = 1'b0;
    clr_req = 1'b0;
    tick();
    checks++;
    if ({clear, clr_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_clr_after: got clr=%b done=%b want 0 0", clear, clr_done);
    end
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_rotate();
    test_pop_empty();
    test_full();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
